glbl_intr_ctrl: RTL and testbench

- Parametrised global interrupt controller; successor to the fixed 8-source interrupt status/mask pair in the global register block.
- Collects NUM_SRC hardware interrupt sources, each with per-source level or rising-edge capture.
- Provides write-1-to-clear (W1C) status, mask, software set, and a highest-priority pending-ID register.
- Drives one registered aggregate IRQ to the RISC-V core; accessed over the existing reg bus (cs/wr/addr/be, single-cycle ack).

---
 rtl/glbl_intr_pkg.sv | 18 +
 rtl/glbl_intr_src.sv | 46 ++++
 rtl/glbl_intr_ctrl.sv | 118 +++++++++++
 tb/tb_glbl_intr_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/glbl_intr_pkg.sv
// Shared register map and CTRL bit layout for the global interrupt controller.
package glbl_intr_pkg;

  localparam logic [3:0] GI_STATUS = 4'h0;
  localparam logic [3:0] GI_MASK   = 4'h1;
  localparam logic [3:0] GI_MODE   = 4'h2;
  localparam logic [3:0] GI_SET    = 4'h3;
  localparam logic [3:0] GI_PEND   = 4'h4;
  localparam logic [3:0] GI_ID     = 4'h5;
  localparam logic [3:0] GI_CTRL   = 4'h6;

  localparam int GI_CTRL_EN_BIT = 0;

  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/glbl_intr_src.sv
// One interrupt source: optional 2-flop synchroniser (GLBL_INTR_SYNC_EN),
// level/rising-edge capture and the W1C status flop.
module glbl_intr_src (
  input  logic mclk,
  input  logic h_reset_n,
  input  logic i_intr,
  input  logic i_mode,
  input  logic i_clr,
  input  logic i_swset,
  output logic o_status
);

  logic w_in;
  logic w_set;
  logic r_prev;
  logic r_status;

`ifdef GLBL_INTR_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge mclk) begin
    if (!h_reset_n) r_sync <= '0;
    else            r_sync <= {r_sync[0], i_intr};
  end

  assign w_in = r_sync[1];
`else
  assign w_in = i_intr;
`endif

  // prev tracks the input in both modes so a MODE change never fakes an edge
  assign w_set = i_mode ? (w_in & ~r_prev) : w_in;

  always_ff @(posedge mclk) begin
    if (!h_reset_n) begin
      r_prev   <= 1'b0;
      r_status <= 1'b0;
    end else begin
      r_prev   <= w_in;
      r_status <= (r_status & ~i_clr) | w_set | i_swset;
    end
  end

  assign o_status = r_status;

endmodule

// File: rtl/glbl_intr_ctrl.sv
// Global interrupt controller: W1C status, mask, mode, software set, priority ID
// and aggregate IRQ. Define GLBL_INTR_SYNC_EN to synchronise asynchronous sources.
module glbl_intr_ctrl
  import glbl_intr_pkg::*;
#(
  parameter int          NUM_SRC  = 16,
  parameter logic [31:0] RST_MASK = 32'h0,
  parameter logic [31:0] RST_MODE = 32'h0
) (
  input  logic               mclk,
  input  logic               h_reset_n,
  input  logic               reg_cs,
  input  logic               reg_wr,
  input  logic [3:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  input  logic [3:0]         reg_be,
  output logic [31:0]        reg_rdata,
  output logic               reg_ack,
  input  logic [NUM_SRC-1:0] intr_in,
  output logic               irq_o,
  output logic [4:0]         irq_id,
  output logic               irq_id_vld
);

  logic               r_ack;
  logic [31:0]        r_rdata;
  logic [NUM_SRC-1:0] r_mask;
  logic [NUM_SRC-1:0] r_mode;
  logic               r_glbl_en;
  logic               r_irq;
  logic [4:0]         r_id;
  logic               r_id_vld;

  logic               w_wr;
  logic [31:0]        w_bemask;
  logic [31:0]        w_wdata_m;
  logic [NUM_SRC-1:0] w_status;
  logic [NUM_SRC-1:0] w_pend;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] w_swset;
  logic [4:0]         w_id;
  logic [31:0]        w_rd_mux;
  logic               w_unused_hi;

  // a write lands only on the first cycle of an access, never on the ack cycle
  assign w_wr      = reg_cs & reg_wr & ~r_ack;
  assign w_bemask  = be_to_mask(reg_be);
  assign w_wdata_m = reg_wdata & w_bemask;
  assign w_clr     = (w_wr && reg_addr == GI_STATUS) ? w_wdata_m[NUM_SRC-1:0] : '0;
  assign w_swset   = (w_wr && reg_addr == GI_SET)    ? w_wdata_m[NUM_SRC-1:0] : '0;
  assign w_pend    = w_status & r_mask;
  assign w_unused_hi = ^{w_wdata_m, w_bemask};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    glbl_intr_src u_src (
      .mclk      (mclk),
      .h_reset_n (h_reset_n),
      .i_intr    (intr_in[g]),
      .i_mode    (r_mode[g]),
      .i_clr     (w_clr[g]),
      .i_swset   (w_swset[g]),
      .o_status  (w_status[g])
    );
  end

  // lowest index wins: scan downwards so the last hit is the smallest
  always_comb begin
    w_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_pend[i]) w_id = 5'(i);
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (reg_addr)
      GI_STATUS: w_rd_mux = 32'(w_status);
      GI_MASK:   w_rd_mux = 32'(r_mask);
      GI_MODE:   w_rd_mux = 32'(r_mode);
      GI_PEND:   w_rd_mux = 32'(w_pend);
      GI_ID:     w_rd_mux = {r_id_vld, 26'b0, r_id};
      GI_CTRL:   w_rd_mux = {31'b0, r_glbl_en};
      default:   w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (!h_reset_n) begin
      r_ack     <= 1'b0;
      r_rdata   <= '0;
      r_mask    <= RST_MASK[NUM_SRC-1:0];
      r_mode    <= RST_MODE[NUM_SRC-1:0];
      r_glbl_en <= 1'b0;
      r_irq     <= 1'b0;
      r_id      <= '0;
      r_id_vld  <= 1'b0;
    end else begin
      r_ack <= reg_cs & ~r_ack;
      if (reg_cs && !r_ack) r_rdata <= w_rd_mux;
      if (w_wr && reg_addr == GI_MASK)
        r_mask <= (r_mask & ~w_bemask[NUM_SRC-1:0]) | w_wdata_m[NUM_SRC-1:0];
      if (w_wr && reg_addr == GI_MODE)
        r_mode <= (r_mode & ~w_bemask[NUM_SRC-1:0]) | w_wdata_m[NUM_SRC-1:0];
      if (w_wr && reg_addr == GI_CTRL && reg_be[0])
        r_glbl_en <= reg_wdata[GI_CTRL_EN_BIT];
      r_irq    <= r_glbl_en & (|w_pend);
      r_id     <= w_id;
      r_id_vld <= |w_pend;
    end
  end

  assign reg_ack    = r_ack;
  assign reg_rdata  = r_rdata;
  assign irq_o      = r_irq;
  assign irq_id     = r_id;
  assign irq_id_vld = r_id_vld;

endmodule

// File: tb/tb_glbl_intr_ctrl.sv
// Directed self-checking bench for glbl_intr_ctrl (NUM_SRC=16, reset MASK/MODE=0).
module tb_glbl_intr_ctrl;
  import glbl_intr_pkg::*;

  logic        mclk = 1'b0;
  logic        h_reset_n;
  logic        reg_cs;
  logic        reg_wr;
  logic [3:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_be;
  logic [31:0] reg_rdata;
  logic        reg_ack;
  logic [15:0] intr_in;
  logic        irq_o;
  logic [4:0]  irq_id;
  logic        irq_id_vld;

  int          total = 0;
  int          bad = 0;
  logic [31:0] rd;
  logic        last_ack;

`ifdef GLBL_INTR_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  always #5 mclk = ~mclk;

  glbl_intr_ctrl #(
    .NUM_SRC  (16),
    .RST_MASK (32'h0),
    .RST_MODE (32'h0)
  ) dut (
    .mclk       (mclk),
    .h_reset_n  (h_reset_n),
    .reg_cs     (reg_cs),
    .reg_wr     (reg_wr),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_be     (reg_be),
    .reg_rdata  (reg_rdata),
    .reg_ack    (reg_ack),
    .intr_in    (intr_in),
    .irq_o      (irq_o),
    .irq_id     (irq_id),
    .irq_id_vld (irq_id_vld)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic bus(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                     input logic [3:0] be, output logic [31:0] rdata);
    reg_cs = 1'b1; reg_wr = wr; reg_addr = addr; reg_wdata = wd; reg_be = be;
    cyc(1);
    rdata    = reg_rdata;
    last_ack = reg_ack;
    reg_cs = 1'b0; reg_wr = 1'b0;
    cyc(1);
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] wd);
    logic [31:0] dummy;
    bus(1'b1, addr, wd, 4'hF, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] v;
    bus(1'b0, addr, 32'h0, 4'hF, v);
    chk(tag, v, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    h_reset_n = 1'b0; reg_cs = 1'b0; reg_wr = 1'b0; reg_addr = '0;
    reg_wdata = '0; reg_be = '0; intr_in = '0;
    cyc(3);
    h_reset_n = 1'b1;
    cyc(1);

    // reset state and ack pulse
    chk("rst_irq", {31'b0, irq_o}, 32'h0);
    chk("rst_vld", {31'b0, irq_id_vld}, 32'h0);
    chk("rst_ack", {31'b0, reg_ack}, 32'h0);
    for (int a = 0; a < 7; a++) begin
      bus(1'b0, 4'(a), 32'h0, 4'hF, rd);
      chk($sformatf("rst_rd%0d", a), rd, 32'h0);
      chk($sformatf("rst_ack_hi%0d", a), {31'b0, last_ack}, 32'h1);
      chk($sformatf("rst_ack_lo%0d", a), {31'b0, reg_ack}, 32'h0);
    end
    rd_chk("rd_unmapped", 4'h9, 32'h0);

    // level source 3, mask width and byte enables
    wr(GI_MASK, 32'hFFFF_0008);
    rd_chk("mask_width", GI_MASK, 32'h0000_0008);
    bus(1'b1, GI_MASK, 32'h0000_FF08, 4'h1, rd);
    rd_chk("mask_be", GI_MASK, 32'h0000_0008);
    wr(GI_CTRL, 32'h1);
    rd_chk("ctrl_rd", GI_CTRL, 32'h1);
    intr_in[3] = 1'b1;
    cyc(6);
    chk("lvl_irq", {31'b0, irq_o}, 32'h1);
    rd_chk("lvl_id", GI_ID, 32'h8000_0003);
    rd_chk("lvl_status", GI_STATUS, 32'h8);
    rd_chk("lvl_pend", GI_PEND, 32'h8);
    wr(GI_STATUS, 32'h8);
    rd_chk("lvl_reset_after_w1c", GI_STATUS, 32'h8);
    intr_in[3] = 1'b0;
    cyc(4);
    wr(GI_STATUS, 32'h8);
    cyc(2);
    chk("lvl_irq_off", {31'b0, irq_o}, 32'h0);
    rd_chk("lvl_status_off", GI_STATUS, 32'h0);
    rd_chk("lvl_id_off", GI_ID, 32'h0);

    // edge source 5
    wr(GI_MODE, 32'h20);
    wr(GI_MASK, 32'h20);
    rd_chk("mode_rd", GI_MODE, 32'h20);
    intr_in[5] = 1'b1;
    cyc(10);
    rd_chk("edge_set", GI_STATUS, 32'h20);
    wr(GI_STATUS, 32'h20);
    cyc(3);
    rd_chk("edge_stay_clr", GI_STATUS, 32'h0);
    intr_in[5] = 1'b0;
    cyc(5);
    rd_chk("edge_fall", GI_STATUS, 32'h0);
    intr_in[5] = 1'b1;
    cyc(5);
    rd_chk("edge_reset", GI_STATUS, 32'h20);
    intr_in[5] = 1'b0;
    cyc(4);
    wr(GI_MODE, 32'h0);
    rd_chk("mode_chg_keeps", GI_STATUS, 32'h20);
    wr(GI_STATUS, 32'h20);
    rd_chk("edge_clr", GI_STATUS, 32'h0);

    // priority
    wr(GI_SET, 32'h84);
    rd_chk("set_rd0", GI_SET, 32'h0);
    rd_chk("set_status", GI_STATUS, 32'h84);
    wr(GI_MASK, 32'h84);
    cyc(2);
    chk("prio_id2", {27'b0, irq_id}, 32'd2);
    chk("prio_vld", {31'b0, irq_id_vld}, 32'h1);
    chk("prio_irq", {31'b0, irq_o}, 32'h1);
    wr(GI_MASK, 32'h0);
    cyc(2);
    chk("mask0_vld", {31'b0, irq_id_vld}, 32'h0);
    chk("mask0_irq", {31'b0, irq_o}, 32'h0);
    rd_chk("mask0_status", GI_STATUS, 32'h84);
    rd_chk("mask0_pend", GI_PEND, 32'h0);
    wr(GI_MASK, 32'h84);
    wr(GI_STATUS, 32'h4);
    cyc(2);
    chk("prio_id7", {27'b0, irq_id}, 32'd7);
    rd_chk("prio_id7_rd", GI_ID, 32'h8000_0007);
    rd_chk("prio_pend", GI_PEND, 32'h80);
    bus(1'b1, GI_SET, 32'h0000_0100, 4'h1, rd);
    rd_chk("set_be", GI_STATUS, 32'h80);
    bus(1'b1, GI_STATUS, 32'h0000_0080, 4'h2, rd);
    rd_chk("w1c_be", GI_STATUS, 32'h80);
    wr(GI_CTRL, 32'h0);
    cyc(2);
    chk("glbl_off_irq", {31'b0, irq_o}, 32'h0);
    chk("glbl_off_vld", {31'b0, irq_id_vld}, 32'h1);
    wr(GI_CTRL, 32'h1);

    // set wins over W1C on the same bit
    intr_in[0] = 1'b1;
    cyc(5);
    wr(GI_STATUS, 32'h1);
    rd_chk("collide_keep", GI_STATUS, 32'h81);
    intr_in[0] = 1'b0;
    cyc(4);
    wr(GI_STATUS, 32'h1);
    rd_chk("collide_clr", GI_STATUS, 32'h80);

    // reset during an access
    reg_cs = 1'b1; reg_wr = 1'b0; reg_addr = GI_STATUS; reg_be = 4'hF;
    cyc(1);
    chk("mid_ack_hi", {31'b0, reg_ack}, 32'h1);
    chk("mid_rdata", reg_rdata, 32'h80);
    h_reset_n = 1'b0;
    reg_cs = 1'b0;
    cyc(1);
    chk("mid_ack_lo", {31'b0, reg_ack}, 32'h0);
    chk("mid_rdata0", reg_rdata, 32'h0);
    chk("mid_irq", {31'b0, irq_o}, 32'h0);
    chk("mid_vld", {31'b0, irq_id_vld}, 32'h0);
    h_reset_n = 1'b1;
    cyc(1);
    rd_chk("mid_status", GI_STATUS, 32'h0);
    rd_chk("mid_mask", GI_MASK, 32'h0);
    rd_chk("mid_ctrl", GI_CTRL, 32'h0);

    // input-to-irq latency
    wr(GI_MASK, 32'h2);
    wr(GI_CTRL, 32'h1);
    intr_in[1] = 1'b1;
    for (int k = 1; k <= LAT + 1; k++) begin
      cyc(1);
      chk($sformatf("lat_edge%0d", k), {31'b0, irq_o}, {31'b0, (k >= LAT)});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
